halt_monitor: RTL
=================

HALT_MONITOR -- requirements
Module: halt_monitor

Interface
REQ-001 Parameter HALT_INST, default 32'h0000006F, instruction word treated as a self-loop halt.
REQ-002 Parameter HALT_COUNT, default 5, consecutive matching fetches required to declare halt (range 1..255).
REQ-003 Parameter TOHOST_EN, default 1, enables halt on store to TOHOST_ADDR.
REQ-004 Parameter TOHOST_ADDR, default 32'h00001000, word address of the tohost mailbox.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000000, watchdog limit in RUN cycles; 0 disables the watchdog.
REQ-006 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-007 resetn_i  input  1  asynchronous, active-low reset.
REQ-008 clear_i  input  1  synchronous re-arm request.
REQ-009 inst_valid_i  input  1  inst_i/pc_i carry a fetched instruction this cycle.
REQ-010 inst_i  input  32  fetched instruction word.
REQ-011 pc_i  input  32  address of inst_i.
REQ-012 dmem_we_i  input  1  data-memory write strobe.
REQ-013 dmem_addr_i  input  32  data-memory write address.
REQ-014 dmem_wdata_i  input  32  data-memory write data.
REQ-015 halt_o  output  1  sticky halt indication.
REQ-016 halt_cause_o  output  2  0 NONE, 1 SELF_LOOP, 2 TOHOST, 3 TIMEOUT.
REQ-017 exit_code_o  output  32  tohost data captured at halt; 0 for other causes.
REQ-018 cycle_count_o  output  32  cycles spent in RUN.
REQ-019 match_count_o  output  8  current consecutive self-loop match count.

Function
REQ-020 FSM states SHALL be IDLE, RUN, HALTED; IDLE->RUN on first inst_valid_i=1; RUN->HALTED on any halt event; HALTED->IDLE on clear_i=1.
REQ-021 In RUN, a valid fetch with inst_i==HALT_INST and (match_count_o==0 or pc_i==stored loop PC) SHALL increment match_count_o, saturating at 255, and store pc_i.
REQ-022 In RUN, a valid fetch not satisfying REQ-021 SHALL load match_count_o with 1 if inst_i==HALT_INST (new loop PC stored), else 0.
REQ-023 Cycles with inst_valid_i=0 SHALL hold match_count_o and the stored PC.
REQ-024 A self-loop event SHALL fire in the cycle where the fetch raises match_count_o to HALT_COUNT.
REQ-025 A tohost event SHALL fire when TOHOST_EN=1, state is IDLE or RUN, dmem_we_i=1 and dmem_addr_i==TOHOST_ADDR.
REQ-026 cycle_count_o SHALL increment each RUN cycle, saturate at 32'hFFFFFFFF, and freeze in HALTED.
REQ-027 A timeout event SHALL fire when TIMEOUT_CYCLES!=0, state is RUN and cycle_count_o==TIMEOUT_CYCLES-1.
REQ-028 halt_o, halt_cause_o and exit_code_o SHALL update one cycle after the triggering event (registered, 1-cycle latency).
REQ-029 Simultaneous events SHALL resolve by priority TOHOST > SELF_LOOP > TIMEOUT.
REQ-030 In HALTED, all further events SHALL be ignored; outputs hold until clear_i or reset.
REQ-031 clear_i=1 in any state SHALL zero halt_o, halt_cause_o, exit_code_o, cycle_count_o and match_count_o and enter IDLE next cycle; clear_i wins over a same-cycle event.

Reset
REQ-032 resetn_i=0 SHALL immediately force state IDLE and all outputs and counters to 0, regardless of clock.
REQ-033 Reset deassertion mid-loop SHALL restart detection from zero; no prior matches are retained.

Structure
REQ-034 A shared package halt_pkg SHALL hold the state enum (IDLE/RUN/HALTED), the halt_cause_t enum, and the NONE/SELF_LOOP/TOHOST/TIMEOUT encodings.
REQ-035 The saturating counter SHALL be one parametrised sub-module, sat_counter (width parameter, inc/clear/load ports), instantiated for cycle_count_o and match_count_o.

Verification
REQ-036 Reset, then 5 valid fetches of 32'h0000006F at PC 0x40 -> halt_o=1, halt_cause_o=1 one cycle after fifth fetch.
REQ-037 Four matches at PC 0x40, one fetch of 32'h00000013, then five matches -> no halt until tenth fetch; match_count_o drops to 0 at the break.
REQ-038 Store of 32'h0000002A to 0x1000 in the same cycle as the fifth loop match -> halt_cause_o=2, exit_code_o=32'h0000002A.
REQ-039 TIMEOUT_CYCLES=20, stream of 32'h00000013 -> halt_cause_o=3 with cycle_count_o=20 frozen thereafter.
REQ-040 Matches at alternating PCs 0x40/0x44 -> match_count_o never exceeds 1, no halt.
REQ-041 clear_i asserted in HALTED, then resetn_i pulsed low mid-count (3 matches) -> outputs 0, halt requires 5 fresh matches after release.

Source files
------------

// File: rtl/halt_pkg.sv
// Shared types for the halt monitor: FSM states, halt causes and event arbitration.
package halt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        SELF_LOOP = 2'd1,
        TOHOST    = 2'd2,
        TIMEOUT   = 2'd3
    } halt_cause_t;

    localparam logic [7:0] MATCH_MAX = 8'hFF;

    // Arbitration order when several halt events land in the same cycle.
    function automatic halt_cause_t pick_cause(input logic tohost_ev,
                                               input logic self_ev,
                                               input logic timeout_ev);
        halt_cause_t cause;
        cause = NONE;
        if (tohost_ev)       cause = TOHOST;
        else if (self_ev)    cause = SELF_LOOP;
        else if (timeout_ev) cause = TIMEOUT;
        return cause;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear beats load beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (load_i) begin
            count_o <= load_val_i;
        end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/halt_monitor.sv
// Watches the fetch and store streams of a core and flags a halt on a self-loop,
// a tohost mailbox store or a watchdog timeout.
//
//   state  | meaning
//   IDLE   | armed, waiting for the first fetch; tohost stores still halt
//   RUN    | program executing; cycles counted, all halt events live
//   HALTED | halt latched; cause/exit code held until clear_i or reset
module halt_monitor
    import halt_pkg::*;
#(
    parameter logic [31:0] HALT_INST      = 32'h0000006F,
    parameter int unsigned HALT_COUNT     = 5,
    parameter bit          TOHOST_EN      = 1'b1,
    parameter logic [31:0] TOHOST_ADDR    = 32'h00001000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        clear_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        halt_o,
    output logic [1:0]  halt_cause_o,
    output logic [31:0] exit_code_o,
    output logic [31:0] cycle_count_o,
    output logic [7:0]  match_count_o
);

    localparam logic [7:0] HALT_CNT = 8'(HALT_COUNT);

    state_t      state;
    halt_cause_t cause_q;
    logic [31:0] loop_pc;

    logic        active;
    logic        fetch;
    logic        is_halt_inst;
    logic        same_loop;
    logic        match_inc;
    logic        match_load;
    logic [7:0]  match_load_val;
    logic        self_ev;
    logic        tohost_ev;
    logic        timeout_ev;
    logic        any_ev;
    halt_cause_t next_cause;

    // The fetch that wakes the monitor out of IDLE already counts toward the loop.
    assign active         = (state == IDLE) || (state == RUN);
    assign fetch          = active && inst_valid_i;
    assign is_halt_inst   = (inst_i == HALT_INST);
    assign same_loop      = (match_count_o == 8'd0) || (pc_i == loop_pc);
    assign match_inc      = fetch && is_halt_inst && same_loop;
    assign match_load     = fetch && !(is_halt_inst && same_loop);
    assign match_load_val = is_halt_inst ? 8'd1 : 8'd0;

    assign self_ev    = (match_inc && (match_count_o != MATCH_MAX) &&
                         ((match_count_o + 8'd1) == HALT_CNT)) ||
                        (match_load && is_halt_inst && (HALT_CNT == 8'd1));
    assign tohost_ev  = TOHOST_EN && active && dmem_we_i && (dmem_addr_i == TOHOST_ADDR);
    assign timeout_ev = (TIMEOUT_CYCLES != 32'd0) && (state == RUN) &&
                        (cycle_count_o == (TIMEOUT_CYCLES - 32'd1));
    assign any_ev     = tohost_ev || self_ev || timeout_ev;
    assign next_cause = pick_cause(tohost_ev, self_ev, timeout_ev);

    assign halt_cause_o = cause_q;

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .clear_i    (clear_i),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .inc_i      (state == RUN),
        .count_o    (cycle_count_o)
    );

    sat_counter #(.WIDTH(8)) u_match_cnt (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .clear_i    (clear_i),
        .load_i     (match_load),
        .load_val_i (match_load_val),
        .inc_i      (match_inc),
        .count_o    (match_count_o)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            loop_pc <= '0;
        end else if (clear_i) begin
            loop_pc <= '0;
        end else if (fetch && is_halt_inst) begin
            loop_pc <= pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state       <= IDLE;
            halt_o      <= 1'b0;
            cause_q     <= NONE;
            exit_code_o <= '0;
        end else if (clear_i) begin
            state       <= IDLE;
            halt_o      <= 1'b0;
            cause_q     <= NONE;
            exit_code_o <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (any_ev) begin
                        state       <= HALTED;
                        halt_o      <= 1'b1;
                        cause_q     <= next_cause;
                        exit_code_o <= tohost_ev ? dmem_wdata_i : 32'd0;
                    end else if (state == IDLE && inst_valid_i) begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
